// File: rtl/light_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : light_sequencer                                               |
// | Purpose  : Drives the red/yellow/green phases of the Red Light, Green    |
// |            Light game. GREEN and RED phases last a pseudo-random number  |
// |            of ticks: the 4-bit LFSR value sampled on the entry edge,     |
// |            plus a per-phase minimum. YELLOW has a fixed length.          |
// | Ports    : clk         - system clock (rising edge)                      |
// |            reset       - synchronous, active-high reset                  |
// |            run         - 1 = game active, 0 = force IDLE                 |
// |            lfsr_in     - LFSR output, sampled only on phase entry        |
// |            red/yellow/green - one-hot phase lights, all 0 in IDLE        |
// |            time_left   - ticks remaining in the current phase            |
// |            phase_start - one-cycle pulse on GREEN/RED entry              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module light_sequencer #(
    parameter int TICK_DIV     = 50000000,
    parameter int MIN_GREEN    = 2,
    parameter int MIN_RED      = 2,
    parameter int YELLOW_TICKS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] lfsr_in,
    output logic       red,
    output logic       yellow,
    output logic       green,
    output logic [5:0] time_left,
    output logic       phase_start
);

    localparam int                 c_PRE_W      = $clog2(TICK_DIV);
    localparam logic [c_PRE_W-1:0] c_TICK_LAST  = c_PRE_W'(TICK_DIV - 1);
    localparam logic [5:0]         c_MIN_GREEN  = 6'(MIN_GREEN);
    localparam logic [5:0]         c_MIN_RED    = 6'(MIN_RED);
    localparam logic [5:0]         c_YELLOW     = 6'(YELLOW_TICKS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_RED    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [c_PRE_W-1:0] r_prescaler;
    logic [c_PRE_W-1:0] w_pre_nx;
    logic [5:0]         r_time_left;
    logic [5:0]         w_tl_nx;
    logic               w_ps_nx;
    logic               w_tick;
    logic [5:0]         w_lfsr_ext;
    logic               r_red;
    logic               r_yellow;
    logic               r_green;
    logic               r_phase_start;

    assign w_tick     = (r_prescaler == c_TICK_LAST);
    // MIN <= 48 and lfsr_in <= 15, so the 6-bit sum cannot overflow.
    assign w_lfsr_ext = {2'b00, lfsr_in};

    always_comb begin
        w_state_nx = r_state;
        w_pre_nx   = r_prescaler;
        w_tl_nx    = r_time_left;
        w_ps_nx    = 1'b0;

        if (!run) begin
            // Dropping run aborts any phase immediately; nothing completes.
            w_state_nx = S_IDLE;
            w_pre_nx   = '0;
            w_tl_nx    = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nx = S_GREEN;
                    w_pre_nx   = '0;
                    w_tl_nx    = c_MIN_GREEN + w_lfsr_ext;
                    w_ps_nx    = 1'b1;
                end
                default: begin
                    if (w_tick) begin
                        w_pre_nx = '0;
                        if (r_time_left == 6'd1) begin
                            // Last tick of the phase: enter the next one on
                            // this same edge, with no gap cycle.
                            case (r_state)
                                S_GREEN: begin
                                    w_state_nx = S_YELLOW;
                                    w_tl_nx    = c_YELLOW;
                                end
                                S_YELLOW: begin
                                    w_state_nx = S_RED;
                                    w_tl_nx    = c_MIN_RED + w_lfsr_ext;
                                    w_ps_nx    = 1'b1;
                                end
                                default: begin
                                    w_state_nx = S_GREEN;
                                    w_tl_nx    = c_MIN_GREEN + w_lfsr_ext;
                                    w_ps_nx    = 1'b1;
                                end
                            endcase
                        end else begin
                            w_tl_nx = r_time_left - 6'd1;
                        end
                    end else begin
                        w_pre_nx = r_prescaler + c_PRE_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_prescaler   <= '0;
            r_time_left   <= '0;
            r_red         <= 1'b0;
            r_yellow      <= 1'b0;
            r_green       <= 1'b0;
            r_phase_start <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_prescaler   <= w_pre_nx;
            r_time_left   <= w_tl_nx;
            // Lights are decoded from the next state so they change on the
            // same edge as the state register.
            r_red         <= (w_state_nx == S_RED);
            r_yellow      <= (w_state_nx == S_YELLOW);
            r_green       <= (w_state_nx == S_GREEN);
            r_phase_start <= w_ps_nx;
        end
    end

    assign red         = r_red;
    assign yellow      = r_yellow;
    assign green       = r_green;
    assign time_left   = r_time_left;
    assign phase_start = r_phase_start;

endmodule
`default_nettype wire

// File: tb/tb_light_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_light_sequencer                                            |
// | Purpose  : Self-checking bench for light_sequencer. A phase-level model  |
// |            (phase, duration in ticks, cycles elapsed) predicts every     |
// |            output each cycle; directed scenarios plus random run/reset/  |
// |            lfsr_in stimulus.                                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_light_sequencer;

    localparam int TICK_DIV     = 4;
    localparam int MIN_GREEN    = 2;
    localparam int MIN_RED      = 3;
    localparam int YELLOW_TICKS = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic [3:0] lfsr_in = 4'd0;
    logic       red, yellow, green, phase_start;
    logic [5:0] time_left;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: 0 idle, 1 green, 2 yellow, 3 red.
    int m_phase = 0;
    int m_dur   = 0;
    int m_cyc   = 0;
    bit m_ps    = 0;

    logic [9:0] dut_vec;
    assign dut_vec = {red, yellow, green, phase_start, time_left};

    light_sequencer #(
        .TICK_DIV    (TICK_DIV),
        .MIN_GREEN   (MIN_GREEN),
        .MIN_RED     (MIN_RED),
        .YELLOW_TICKS(YELLOW_TICKS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .lfsr_in    (lfsr_in),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .time_left  (time_left),
        .phase_start(phase_start)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] model_vec();
        logic [2:0] lights;
        logic [5:0] tl;
        case (m_phase)
            1:       lights = 3'b001;
            2:       lights = 3'b010;
            3:       lights = 3'b100;
            default: lights = 3'b000;
        endcase
        tl = (m_phase == 0) ? 6'd0 : 6'(m_dur - m_cyc / TICK_DIV);
        return {lights, m_ps, tl};
    endfunction

    // Drive one cycle of inputs, let the edge happen, advance the model.
    task automatic cycle(input logic rst_v, input logic run_v, input logic [3:0] l);
        reset   = rst_v;
        run     = run_v;
        lfsr_in = l;
        @(posedge clk);
        m_ps = 0;
        if (rst_v || !run_v) begin
            m_phase = 0; m_dur = 0; m_cyc = 0;
        end else if (m_phase == 0) begin
            m_phase = 1; m_dur = MIN_GREEN + int'(l); m_cyc = 0; m_ps = 1;
        end else begin
            m_cyc++;
            if (m_cyc == m_dur * TICK_DIV) begin
                m_cyc = 0;
                case (m_phase)
                    1: begin m_phase = 2; m_dur = YELLOW_TICKS; end
                    2: begin m_phase = 3; m_dur = MIN_RED + int'(l); m_ps = 1; end
                    default: begin m_phase = 1; m_dur = MIN_GREEN + int'(l); m_ps = 1; end
                endcase
            end
        end
        #1;
    endtask

    // Count how many cycles the current light stays on (current cycle = 1),
    // tallying cycles where the DUT disagreed with the model.
    task automatic measure(input logic [3:0] l, input bit tog, output int cnt, output int bad);
        logic [2:0] c;
        c   = {red, yellow, green};
        cnt = 1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, 1'b1, tog ? 4'($urandom) : l);
            if (dut_vec !== model_vec()) bad++;
            if ({red, yellow, green} !== c) break;
            cnt++;
        end
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 4'b0101);
        cycle(1'b1, 1'b1, 4'b0101);
        n_tests++;
        if (dut_vec !== 10'd0) begin
            n_fail++; $display("FAIL reset_state: got %b expected %b", dut_vec, 10'd0);
        end
        n_tests++;
        if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL reset_model: got %b expected %b", dut_vec, model_vec());
        end
    endtask

    task automatic test_green_phase();
        int cnt, bad;
        cycle(1'b0, 1'b1, 4'b0101);
        n_tests++;
        if (dut_vec !== {3'b001, 1'b1, 6'd7}) begin
            n_fail++; $display("FAIL green_entry: got %b expected %b", dut_vec, {3'b001, 1'b1, 6'd7});
        end
        measure(4'b0101, 1'b0, cnt, bad);
        n_tests++;
        if (cnt !== 28 || bad !== 0) begin
            n_fail++; $display("FAIL green_len: got %0d cycles (%0d bad) expected 28 (0 bad)", cnt, bad);
        end
        n_tests++;
        if (dut_vec !== {3'b010, 1'b0, 6'd1}) begin
            n_fail++; $display("FAIL yellow_entry: got %b expected %b", dut_vec, {3'b010, 1'b0, 6'd1});
        end
    endtask

    task automatic test_yellow_red();
        int cnt, bad;
        measure(4'b0011, 1'b0, cnt, bad);
        n_tests++;
        if (cnt !== 4 || bad !== 0) begin
            n_fail++; $display("FAIL yellow_len: got %0d cycles (%0d bad) expected 4 (0 bad)", cnt, bad);
        end
        n_tests++;
        if (dut_vec !== {3'b100, 1'b1, 6'd6}) begin
            n_fail++; $display("FAIL red_entry: got %b expected %b", dut_vec, {3'b100, 1'b1, 6'd6});
        end
        measure(4'b0011, 1'b0, cnt, bad);
        n_tests++;
        if (cnt !== 24 || bad !== 0) begin
            n_fail++; $display("FAIL red_len: got %0d cycles (%0d bad) expected 24 (0 bad)", cnt, bad);
        end
        n_tests++;
        if (dut_vec !== {3'b001, 1'b1, 6'd5}) begin
            n_fail++; $display("FAIL green_reentry: got %b expected %b", dut_vec, {3'b001, 1'b1, 6'd5});
        end
    endtask

    task automatic test_lfsr_bounds();
        int cnt, bad;
        cycle(1'b0, 1'b0, 4'd0);
        n_tests++;
        if (dut_vec !== 10'd0) begin
            n_fail++; $display("FAIL run_low_idle: got %b expected %b", dut_vec, 10'd0);
        end
        cycle(1'b0, 1'b1, 4'd0);
        n_tests++;
        if (dut_vec !== {3'b001, 1'b1, 6'd2}) begin
            n_fail++; $display("FAIL lfsr_min_entry: got %b expected %b", dut_vec, {3'b001, 1'b1, 6'd2});
        end
        measure(4'd0, 1'b0, cnt, bad);
        n_tests++;
        if (cnt !== 8 || bad !== 0) begin
            n_fail++; $display("FAIL lfsr_min_len: got %0d cycles (%0d bad) expected 8 (0 bad)", cnt, bad);
        end
        cycle(1'b0, 1'b0, 4'd15);
        cycle(1'b0, 1'b1, 4'd15);
        n_tests++;
        if (dut_vec !== {3'b001, 1'b1, 6'd17}) begin
            n_fail++; $display("FAIL lfsr_max_entry: got %b expected %b", dut_vec, {3'b001, 1'b1, 6'd17});
        end
        measure(4'd15, 1'b0, cnt, bad);
        n_tests++;
        if (cnt !== 68 || bad !== 0) begin
            n_fail++; $display("FAIL lfsr_max_len: got %0d cycles (%0d bad) expected 68 (0 bad)", cnt, bad);
        end
    endtask

    task automatic test_lfsr_toggle();
        int cnt, bad;
        cycle(1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b1, 4'd6);
        n_tests++;
        if (dut_vec !== {3'b001, 1'b1, 6'd8}) begin
            n_fail++; $display("FAIL toggle_entry: got %b expected %b", dut_vec, {3'b001, 1'b1, 6'd8});
        end
        measure(4'd0, 1'b1, cnt, bad);
        n_tests++;
        if (cnt !== 32 || bad !== 0) begin
            n_fail++; $display("FAIL toggle_len: got %0d cycles (%0d bad) expected 32 (0 bad)", cnt, bad);
        end
    endtask

    task automatic test_run_drop();
        int cnt, bad;
        measure(4'd0, 1'b0, cnt, bad);   // yellow, then red with duration 3
        n_tests++;
        if (red !== 1'b1 || time_left !== 6'd3 || bad !== 0) begin
            n_fail++; $display("FAIL red_min: got red=%b tl=%0d bad=%0d expected red=1 tl=3 bad=0", red, time_left, bad);
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'd0);
        cycle(1'b0, 1'b0, 4'd0);
        n_tests++;
        if (dut_vec !== 10'd0) begin
            n_fail++; $display("FAIL run_drop_red: got %b expected %b", dut_vec, 10'd0);
        end
        cycle(1'b0, 1'b1, 4'd10);
        n_tests++;
        if (dut_vec !== {3'b001, 1'b1, 6'd12}) begin
            n_fail++; $display("FAIL run_restart: got %b expected %b", dut_vec, {3'b001, 1'b1, 6'd12});
        end
        // run falling on the very edge that would end a phase must win.
        cycle(1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 4'd0);
        n_tests++;
        if (dut_vec !== {3'b001, 1'b0, 6'd1}) begin
            n_fail++; $display("FAIL pre_end_green: got %b expected %b", dut_vec, {3'b001, 1'b0, 6'd1});
        end
        cycle(1'b0, 1'b0, 4'd0);
        n_tests++;
        if (dut_vec !== 10'd0) begin
            n_fail++; $display("FAIL run_drop_on_end: got %b expected %b", dut_vec, 10'd0);
        end
    endtask

    task automatic test_reset_mid();
        int cnt, bad;
        cycle(1'b0, 1'b1, 4'd9);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'd9);
        cycle(1'b1, 1'b1, 4'd9);
        n_tests++;
        if (dut_vec !== 10'd0) begin
            n_fail++; $display("FAIL reset_mid: got %b expected %b", dut_vec, 10'd0);
        end
        cycle(1'b0, 1'b1, 4'd4);
        n_tests++;
        if (dut_vec !== {3'b001, 1'b1, 6'd6}) begin
            n_fail++; $display("FAIL reset_release: got %b expected %b", dut_vec, {3'b001, 1'b1, 6'd6});
        end
        measure(4'd4, 1'b0, cnt, bad);
        n_tests++;
        if (cnt !== 24 || bad !== 0) begin
            n_fail++; $display("FAIL reset_full_len: got %0d cycles (%0d bad) expected 24 (0 bad)", cnt, bad);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 99) != 0, 4'($urandom));
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got %b expected %b", i, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_green_phase();
        test_yellow_red();
        test_lfsr_bounds();
        test_lfsr_toggle();
        test_run_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/light_sequencer.md
Name: light_sequencer

Overview:
- Consumer end of the 4-bit LFSR interface: takes the LFSR's `out` value on `lfsr_in` and drives the red/yellow/green light phases of the Red Light, Green Light game.
- Each GREEN and RED phase gets a pseudo-random duration: the LFSR value sampled at phase entry, plus a minimum.
- Contains an internal tick prescaler, a per-phase countdown, and a 4-state FSM.
- Sits between `lfsr` and the game/scoring and display logic.

Parameters:
- TICK_DIV, 50000000, clock cycles per tick (1 s at 50 MHz); integer ≥ 2.
- MIN_GREEN, 2, minimum GREEN duration in ticks; range 1..48.
- MIN_RED, 2, minimum RED duration in ticks; range 1..48.
- YELLOW_TICKS, 1, fixed YELLOW duration in ticks; range 1..63.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  level; 1 = game active, 0 = force IDLE.
- lfsr_in  input  4  current LFSR output; sampled only on phase-entry edges.
- red  output  1  RED phase active.
- yellow  output  1  YELLOW phase active.
- green  output  1  GREEN phase active.
- time_left  output  6  ticks remaining in the current phase.
- phase_start  output  1  one-cycle pulse on the first cycle of each GREEN or RED phase.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset values: state=IDLE; red=yellow=green=0; time_left=0; phase_start=0; prescaler=0.
  - Reset has priority over run and over every other condition.
- All outputs are registered.
- States are IDLE, GREEN, YELLOW, RED.
  - red, yellow and green are one-hot in GREEN, YELLOW and RED, and all 0 in IDLE.
- run=0 in any state:
  - Next edge: state=IDLE, lights=0, time_left=0, prescaler=0, phase_start=0.
  - This applies mid-phase, and no phase completes.
- IDLE → GREEN at the first edge with run=1.
- Phase entry, on the same edge the state changes:
  - GREEN: time_left = MIN_GREEN + lfsr_in, using the value of lfsr_in present at that edge.
  - RED: time_left = MIN_RED + lfsr_in.
  - YELLOW: time_left = YELLOW_TICKS.
  - Prescaler cleared to 0.
  - phase_start=1 for exactly that cycle, on GREEN and RED entry only.
- Width rule:
  - The sum is zero-extended 4-bit + 6-bit into 6 bits.
  - Max MIN+15 = 63, so there is no overflow.
  - lfsr_in=0 is legal and gives duration = MIN.
- Prescaler:
  - In active states it counts 0..TICK_DIV-1 and wraps to 0.
  - tick = (prescaler == TICK_DIV-1).
- On each tick with time_left > 1: time_left decrements by 1.
- On a tick with time_left == 1, the phase ends and the next edge enters the next phase:
  - GREEN → YELLOW
  - YELLOW → RED
  - RED → GREEN
  - No cycle passes through IDLE and there is no gap cycle.
- Each phase lasts exactly duration × TICK_DIV cycles.
- lfsr_in changes inside a phase are ignored. Only entry edges sample it.
- time_left never reaches 0 in active states. It reads 0 only in IDLE.
- If run falls on the same edge as a phase-end tick, IDLE wins.
- run rising again after IDLE starts a fresh GREEN with a new sample. There is no resume.

Test Plan:
Bench overrides TICK_DIV=4, MIN_GREEN=2, MIN_RED=3, YELLOW_TICKS=1.
1. Reset 2 cycles, run=1, lfsr_in=4'b0101 → next cycle green=1, time_left=7, phase_start=1 for 1 cycle; green held 28 cycles; time_left steps 7→1 every 4 cycles.
2. Continue from 1 with lfsr_in=4'b0011 during YELLOW → yellow=1 for exactly 4 cycles; then red=1, time_left=6 (MIN_RED+3), phase_start pulse; red held 24 cycles; then green re-enters, sampling the current lfsr_in.
3. lfsr_in=4'b0000 at GREEN entry → time_left=2, green 8 cycles. lfsr_in=4'b1111 → time_left=17, green 68 cycles, no wrap.
4. Toggle lfsr_in every cycle during GREEN → time_left is unaffected and phase length is unchanged.
5. run=0 mid-RED → next cycle all lights 0, time_left=0. Re-assert run → GREEN next cycle with a fresh sample and phase_start=1.
6. reset=1 mid-GREEN with run=1 → IDLE at the next edge, all outputs 0. Release reset with run=1 → GREEN one cycle later, full duration.
